// File: rtl/operand_loader_pkg.sv
// Shared constants for operand_loader: FSM state encoding and nibble width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package operand_loader_pkg;

    localparam int NIB = 4;

    // 2'b11 is deliberately left unencoded; the FSM recovers from it to LOAD_A.
    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        HOLD   = 2'b10
    } state_e;

    // Number of nibble beats needed to fill one operand of width w.
    function automatic int beats_for(input int w);
        return w / NIB;
    endfunction

endpackage

// File: rtl/operand_loader_edge_det.sv
// Rising-edge detector for a level input (push-button style load strobe).
// Latency: combinational rise output, one flop of history.
// Backpressure: none; ports clk, rst_n (sync, active-low), d, rise.
// Built only with OPERAND_LOADER_LOAD_EDGE_EN, the only build that uses it.
`ifdef OPERAND_LOADER_LOAD_EDGE_EN
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule
`endif

// File: rtl/operand_loader.sv
// Loads two WIDTH-bit operands nibble by nibble (MSB first, A then B) and holds the pair.
// Latency: 2*WIDTH/4 accepted nibbles to op_valid; pair released on op_valid && op_ready.
// Backpressure: while op_valid && !op_ready the pair is frozen and din_load is ignored.
// Ports: clk, rst_n (sync, active-low), din/din_load (nibble input + strobe), clr (sync abort),
//        op_a/op_b/op_valid/op_ready (operand pair handshake), state_o (FSM state for LEDs).
// Build option: OPERAND_LOADER_LOAD_EDGE_EN makes din_load a level; a nibble is taken
//               only on its 0->1 transition.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       din,
    input  logic             din_load,
    input  logic             clr,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       state_o
);

    localparam int BEATS = beats_for(WIDTH);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             load_acc;
    logic             last_beat;

`ifdef OPERAND_LOADER_LOAD_EDGE_EN
    logic load_rise;

    edge_det u_edge_det (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (din_load),
        .rise (load_rise)
    );

    assign load_acc = load_rise;
`else
    assign load_acc = din_load;
`endif

    assign last_beat = (beat_q == CW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;

        if (clr) begin
            // Abort wins over loading and over a pending handshake.
            state_d = LOAD_A;
            beat_d  = '0;
            op_a_d  = '0;
            op_b_d  = '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (load_acc) begin
                        // Truncating the concat drops the oldest nibble: MSB-first shift.
                        op_a_d = WIDTH'({op_a_q, din});
                        if (last_beat) begin
                            beat_d  = '0;
                            state_d = LOAD_B;
                        end else begin
                            beat_d = beat_q + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (load_acc) begin
                        op_b_d = WIDTH'({op_b_q, din});
                        if (last_beat) begin
                            beat_d  = '0;
                            state_d = HOLD;
                        end else begin
                            beat_d = beat_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // Operands are kept after the handshake so the downstream OR stays stable.
                    if (op_ready) begin
                        state_d = LOAD_A;
                        beat_d  = '0;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    beat_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            beat_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = (state_q == HOLD);
    assign state_o  = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader (WIDTH=8): directed scenarios plus random traffic,
// checked by a scoreboard fed from a nibble-count reference model.
module tb_operand_loader;

    localparam int W = 8;
    localparam int B = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   din = 4'h0;
    logic         din_load = 1'b0;
    logic         clr = 1'b0;
    logic         op_ready = 1'b0;
    logic [W-1:0] op_a, op_b;
    logic         op_valid;
    logic [1:0]   state_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    // Reference model: number of nibbles taken into the current pair, operand values,
    // previous din_load level (edge mode), and the queue of completed pairs awaiting handshake.
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic         m_prev = 1'b0;
    logic [2*W-1:0] exp_q[$];

    operand_loader #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .din_load(din_load),
        .clr     (clr),
        .op_a    (op_a),
        .op_b    (op_b),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_state(input int cnt);
        if (cnt < B)          return 2'b00;
        else if (cnt < 2 * B) return 2'b01;
        else                  return 2'b10;
    endfunction

    // Apply the effect of one clock edge with the given inputs to the model.
    task automatic model_update(input logic l, input logic [3:0] d, input logic c,
                                input logic r, input logic rs);
        logic take;
        if (!rs) begin
            m_cnt = 0; m_a = '0; m_b = '0; exp_q.delete();
        end else if (c) begin
            m_cnt = 0; m_a = '0; m_b = '0; exp_q.delete();
        end else if (m_cnt == 2 * B) begin
            if (r) m_cnt = 0;   // pair was popped by the monitor
        end else begin
`ifdef OPERAND_LOADER_LOAD_EDGE_EN
            take = l && !m_prev;
`else
            take = l;
`endif
            if (take) begin
                if (m_cnt < B) m_a = W'(m_a * 16 + d);
                else           m_b = W'(m_b * 16 + d);
                m_cnt++;
                if (m_cnt == 2 * B) exp_q.push_back({m_a, m_b});
            end
        end
        m_prev = rs ? l : 1'b0;
    endtask

    // Called at posedge+1; drives inputs, waits for the edge, updates the model.
    task automatic cycle(input logic l, input logic [3:0] d, input logic c,
                         input logic r, input logic rs);
        din_load = l; din = d; clr = c; op_ready = r; rst_n = rs;
        @(posedge clk);
        #1;
        model_update(l, d, c, r, rs);
    endtask

    task automatic load_nib(input logic [3:0] d, input logic r);
        cycle(1'b1, d, 1'b0, r, 1'b1);
    endtask

    task automatic gap(input logic r);
`ifdef OPERAND_LOADER_LOAD_EDGE_EN
        cycle(1'b0, 4'h0, 1'b0, r, 1'b1);
`else
        if (r === 1'bx) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
`endif
    endtask

    // Monitor: compares DUT against model mid-cycle, pops the scoreboard on a real handshake.
    always @(negedge clk) begin
        logic [2*W-1:0] p;
        if (mon_en) begin
            chk("state_o", {30'd0, state_o}, {30'd0, exp_state(m_cnt)});
            chk("op_valid", {31'd0, op_valid}, {31'd0, (m_cnt == 2 * B)});
            chk("op_a", {24'd0, op_a}, {24'd0, m_a});
            chk("op_b", {24'd0, op_b}, {24'd0, m_b});
            if (op_valid && op_ready && !clr && rst_n) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL pair: handshake with empty scoreboard, got %0h", {op_a, op_b});
                end else begin
                    p = exp_q.pop_front();
                    chk("pair", {16'd0, op_a, op_b}, {16'd0, p});
                end
            end
        end
    end

    initial begin
        int vcnt;
        // Reset
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_a", {24'd0, op_a}, 32'd0);
        chk("rst_b", {24'd0, op_b}, 32'd0);
        chk("rst_valid", {31'd0, op_valid}, 32'd0);
        mon_en = 1'b1;

        // Unused state 2'b11 recovers to LOAD_A
        mon_en = 1'b0;
        din_load = 1'b0; clr = 1'b0; op_ready = 1'b0; rst_n = 1'b1;
        force dut.state_q = operand_loader_pkg::state_e'(2'b11);
        @(negedge clk);
        #1;
        release dut.state_q;
        @(posedge clk);
        #1;
        chk("unused_state", {30'd0, state_o}, 32'd0);
        mon_en = 1'b1;

        // Nominal load A,5,0,F with op_ready held high
        load_nib(4'hA, 1'b1); gap(1'b1);
        load_nib(4'h5, 1'b1); gap(1'b1);
        load_nib(4'h0, 1'b1); gap(1'b1);
        load_nib(4'hF, 1'b1);
        chk("nom_valid", {31'd0, op_valid}, 32'd1);
        chk("nom_a", {24'd0, op_a}, 32'hA5);
        chk("nom_b", {24'd0, op_b}, 32'h0F);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("nom_valid_drop", {31'd0, op_valid}, 32'd0);
        chk("nom_state", {30'd0, state_o}, 32'd0);
        chk("nom_or", {24'd0, (op_a | op_b)}, 32'hAF);

        // clr mid-load, same cycle as din_load
        load_nib(4'h1, 1'b0); gap(1'b0);
        load_nib(4'h2, 1'b0); gap(1'b0);
        load_nib(4'h3, 1'b0); gap(1'b0);
        cycle(1'b1, 4'h4, 1'b1, 1'b0, 1'b1);
        chk("clr_state", {30'd0, state_o}, 32'd0);
        chk("clr_a", {24'd0, op_a}, 32'd0);
        chk("clr_b", {24'd0, op_b}, 32'd0);
        chk("clr_valid", {31'd0, op_valid}, 32'd0);
        gap(1'b0);
        load_nib(4'h6, 1'b0); gap(1'b0);
        load_nib(4'h7, 1'b0); gap(1'b0);
        load_nib(4'h8, 1'b0); gap(1'b0);
        load_nib(4'h9, 1'b0);
        chk("fresh_a", {24'd0, op_a}, 32'h67);
        chk("fresh_b", {24'd0, op_b}, 32'h89);

        // Backpressure: 5 cycles in HOLD with loads of 3 that must be ignored
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
        chk("bp_valid", {31'd0, op_valid}, 32'd1);
        chk("bp_a", {24'd0, op_a}, 32'h67);
        chk("bp_b", {24'd0, op_b}, 32'h89);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("bp_release", {30'd0, state_o}, 32'd0);
        chk("bp_hold_a", {24'd0, op_a}, 32'h67);

        // Reset while in HOLD
        load_nib(4'hC, 1'b0); gap(1'b0);
        load_nib(4'hD, 1'b0); gap(1'b0);
        load_nib(4'hE, 1'b0); gap(1'b0);
        load_nib(4'hB, 1'b0);
        chk("pre_rst_valid", {31'd0, op_valid}, 32'd1);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("hold_rst_valid", {31'd0, op_valid}, 32'd0);
        chk("hold_rst_a", {24'd0, op_a}, 32'd0);
        chk("hold_rst_b", {24'd0, op_b}, 32'd0);
        chk("hold_rst_state", {30'd0, state_o}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 149) != 0);
        end

`ifdef OPERAND_LOADER_LOAD_EDGE_EN
        // Level-held loads: 4 presses of 3 cycles each -> one pair, one valid cycle
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        vcnt = 0;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 3; k++) begin
                cycle(1'b1, 4'(g + 1), 1'b0, 1'b1, 1'b1);
                if (op_valid) vcnt++;
            end
            cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
            if (op_valid) vcnt++;
        end
        chk("edge_valid_cycles", 32'(vcnt), 32'd1);
        chk("edge_a", {24'd0, op_a}, 32'h12);
        chk("edge_b", {24'd0, op_b}, 32'h34);
`else
        vcnt = 0;
`endif

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
- REQ-001: Parameter WIDTH, default 8; operand width in bits; SHALL be a multiple of 4 and at least 4.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst_n  input  1  reset, synchronous, active-low.
- REQ-004: din  input  4  nibble presented for loading.
- REQ-005: din_load  input  1  load strobe; one nibble is accepted per qualifying cycle.
- REQ-006: clr  input  1  synchronous abort/clear, active-high.
- REQ-007: op_a  output  WIDTH  registered operand A, feeds the downstream OR stage input a.
- REQ-008: op_b  output  WIDTH  registered operand B, feeds the downstream OR stage input b.
- REQ-009: op_valid  output  1  op_a/op_b form a complete, stable operand pair.
- REQ-010: op_ready  input  1  downstream consumer accepts the pair.
- REQ-011: state_o  output  2  current FSM state, for LED display.

Function
- REQ-012: BEATS = WIDTH/4 nibbles per operand; a beat counter SHALL count 0..BEATS-1 and wrap to 0 on the last beat.
- REQ-013: FSM states: LOAD_A=2'b00, LOAD_B=2'b01, HOLD=2'b10; 2'b11 is unused and SHALL transition to LOAD_A.
- REQ-014: In LOAD_A, each accepted nibble shifts into A MSB-first: op_a <= {op_a[WIDTH-5:0], din}.
  - The BEATS-th accepted nibble moves the FSM to LOAD_B.
- REQ-015: In LOAD_B, nibbles shift into op_b the same way.
  - The BEATS-th accepted nibble moves the FSM to HOLD.
- REQ-016: op_valid SHALL equal (state==HOLD).
  - It asserts on the clock edge that accepts the final B nibble, so it is high in the next cycle.
  - Latency from the first A nibble to op_valid is 2*BEATS cycles with back-to-back loads.
- REQ-017: In HOLD, din_load SHALL be ignored; op_a and op_b SHALL not change.
- REQ-018: The handshake completes on any cycle where op_valid && op_ready.
  - On that edge the FSM returns to LOAD_A and the beat counter returns to 0.
  - op_a and op_b retain their values, so the downstream OR output stays stable until overwritten.
- REQ-019: op_ready while not in HOLD SHALL have no effect.
- REQ-020: clr SHALL take priority over din_load and over the handshake.
  - Next state is LOAD_A, beat counter 0, op_a=0, op_b=0.
- REQ-021: din_load with no state change pending (back-to-back every cycle) SHALL accept one nibble per cycle with no bubble.
  - This includes the LOAD_A to LOAD_B boundary.

Reset
- REQ-022: While rst_n=0 at a rising edge, the block SHALL set:
  - state LOAD_A, beat counter 0;
  - op_a=0, op_b=0, op_valid=0, state_o=2'b00;
  - the edge-detect history register (if present) to 0.
- REQ-023: Reset SHALL take priority over clr, din_load and handshake.
  - Reset mid-load or in HOLD discards all partial data.

Configuration
- REQ-024: Macro OPERAND_LOADER_LOAD_EDGE_EN.
  - When defined: din_load is treated as a level (push-button).
  - A nibble is accepted only on the cycle where din_load=1 and din_load was 0 in the previous cycle.
- REQ-025: When OPERAND_LOADER_LOAD_EDGE_EN is undefined: a nibble is accepted on every cycle with din_load=1, and no history register exists.

Structure
- REQ-026: Package operand_loader_pkg SHALL hold:
  - the state encoding constants LOAD_A, LOAD_B, HOLD;
  - the nibble width constant NIB=4.
- REQ-027: Rising-edge detection SHALL live in sub-module edge_det (ports clk, rst_n, d, rise).
  - It is instantiated only under OPERAND_LOADER_LOAD_EDGE_EN.

Verification (WIDTH=8, macro undefined unless stated)
- REQ-028: Nominal load with op_ready held at 1.
  - Stimulus: load nibbles A,5,0,F on 4 consecutive cycles.
  - Response: op_a=8'hA5, op_b=8'h0F, op_valid=1 for exactly 1 cycle, then state_o=00 with op_a/op_b held; downstream OR gives 8'hAF.
- REQ-029: Backpressure.
  - Stimulus: op_ready=0 for 5 cycles in HOLD, with din_load=1, din=4'h3 throughout.
  - Response: op_valid stays 1 and op_a/op_b are unchanged; raising op_ready returns the FSM to LOAD_A on the next edge.
- REQ-030: clr mid-load.
  - Stimulus: clr asserted after A complete plus one B nibble, in the same cycle as din_load.
  - Response: state_o=00, op_a=0, op_b=0, op_valid=0, and the next 4 loads form a fresh pair.
- REQ-031: Reset in HOLD.
  - Stimulus: rst_n=0 for 1 cycle while in HOLD.
  - Response: all outputs 0 after the edge and op_valid=0.
- REQ-032: Macro defined, edge detection.
  - Stimulus: din_load held high for 3 cycles, then low, 4 times.
  - Response: exactly 4 nibbles accepted and op_valid asserts once.
- REQ-033: Unused state.
  - Stimulus: force state to 2'b11.
  - Response: LOAD_A on the next edge.
